// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: FSM states, forwarding selects,
// scoreboard entry layout and the source-match helper.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       load;
  } sb_entry_t;

  localparam int unsigned SB_DEPTH = 3;
  localparam int unsigned SB_EX    = 0;
  localparam int unsigned SB_MEM   = 1;
  localparam int unsigned SB_WB    = 2;

  // x0 is hard-wired zero, so it never depends on a producer.
  function automatic logic src_hit(input logic use_src, input logic [4:0] rs,
                                   input logic valid, input logic [4:0] rd);
    return use_src && valid && (rd == rs) && (rs != 5'd0);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// EX/MEM/WB destination scoreboard, shifted every cycle, with per-source
// match vectors (bit 0 = EX, 1 = MEM, 2 = WB).
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [4:0]          rs1,
  input  logic [4:0]          rs2,
  input  logic                use_rs1,
  input  logic                use_rs2,
  input  logic [4:0]          rd,
  input  logic                regwrite,
  input  logic                load,
  input  logic                bubble,
  output logic [SB_DEPTH-1:0] match_a,
  output logic [SB_DEPTH-1:0] match_b
`ifdef FORWARDING_EN
  ,
  output logic                ex_load
`endif
);

  sb_entry_t sb [SB_DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < SB_DEPTH; i++) sb[i] <= '0;
    end else begin
      sb[SB_EX] <= '{valid: regwrite && (rd != 5'd0) && !bubble, rd: rd, load: load};
      for (int unsigned i = 1; i < SB_DEPTH; i++) sb[i] <= sb[i-1];
    end
  end

  always_comb begin
    match_a = '0;
    match_b = '0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      match_a[i] = src_hit(use_rs1, rs1, sb[i].valid, sb[i].rd);
      match_b[i] = src_hit(use_rs2, rs2, sb[i].valid, sb[i].rd);
    end
  end

`ifdef FORWARDING_EN
  assign ex_load = sb[SB_EX].load;
`endif

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: RAW stall/bubble, branch flush, operand forwarding
// selects and a saturating stall counter. Define FORWARDING_EN to enable bypassing.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             use_rs1_ID,
  input  logic             use_rs2_ID,
  input  logic [4:0]       rd_ID,
  input  logic             regwrite_ID,
  input  logic             load_ID,
  input  logic             redirect_EX,
  output logic             stall_IF,
  output logic             bubble_ID,
  output logic             flush_IF,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t              state, state_nx;
  logic [SB_DEPTH-1:0] match_a, match_b;
  logic                hazard;
  logic [CNT_W-1:0]    cnt_q;

`ifdef FORWARDING_EN
  logic ex_load;
`endif

  hazard_scoreboard u_sb (
    .clk      (clock),
    .reset    (reset),
    .rs1      (rs1_ID),
    .rs2      (rs2_ID),
    .use_rs1  (use_rs1_ID),
    .use_rs2  (use_rs2_ID),
    .rd       (rd_ID),
    .regwrite (regwrite_ID),
    .load     (load_ID),
    .bubble   (bubble_ID),
    .match_a  (match_a),
    .match_b  (match_b)
`ifdef FORWARDING_EN
    ,
    .ex_load  (ex_load)
`endif
  );

`ifdef FORWARDING_EN
  logic [1:0] sel_a, sel_b, fwd_a_q, fwd_b_q;

  function automatic logic [1:0] fwd_pick(input logic hit_ex, input logic hit_mem,
                                          input logic ld);
    if (hit_ex && !ld) return FWD_MEM;
    if (hit_mem)       return FWD_WB;
    return FWD_RF;
  endfunction

  assign hazard = ex_load && (match_a[SB_EX] || match_b[SB_EX]);
  assign sel_a  = fwd_pick(match_a[SB_EX], match_a[SB_MEM], ex_load);
  assign sel_b  = fwd_pick(match_b[SB_EX], match_b[SB_MEM], ex_load);

  // A bubble entering EX has no operands to bypass.
  always_ff @(posedge clock) begin
    if (reset) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      fwd_a_q <= bubble_ID ? FWD_RF : sel_a;
      fwd_b_q <= bubble_ID ? FWD_RF : sel_b;
    end
  end

  assign fwd_a = reset ? FWD_RF : fwd_a_q;
  assign fwd_b = reset ? FWD_RF : fwd_b_q;
`else
  assign hazard = (|match_a) || (|match_b);
  assign fwd_a  = FWD_RF;
  assign fwd_b  = FWD_RF;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nx;
  end

  // STALL and RUN share one hazard-driven output path so the stall releases in
  // the same cycle the hazard clears; STALL only records that we are stalling.
  always_comb begin
    state_nx  = state;
    stall_IF  = 1'b0;
    bubble_ID = 1'b0;
    flush_IF  = 1'b0;
    if (reset) begin
      state_nx = ST_RUN;
    end else if (redirect_EX) begin
      flush_IF  = 1'b1;
      bubble_ID = 1'b1;
      state_nx  = ST_FLUSH;
    end else begin
      case (state)
        ST_FLUSH: begin
          bubble_ID = 1'b1;
          state_nx  = ST_RUN;
        end
        default: begin
          if (hazard) begin
            stall_IF  = 1'b1;
            bubble_ID = 1'b1;
            state_nx  = ST_STALL;
          end else begin
            state_nx = ST_RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset)                          cnt_q <= '0;
    else if (stall_IF && cnt_q != '1)   cnt_q <= cnt_q + CNT_W'(1);
  end

  assign stall_cnt = reset ? '0 : cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a timestamped producer model checked every cycle,
// plus directed sequences with hand-computed expectations.
module tb_hazard_ctrl;

  localparam int unsigned CW = 3;
`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic [4:0]    rs1_ID, rs2_ID, rd_ID;
  logic          use_rs1_ID, use_rs2_ID, regwrite_ID, load_ID, redirect_EX;
  logic          stall_IF, bubble_ID, flush_IF;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  hazard_ctrl #(.CNT_W(CW)) dut (
    .clock       (clock),
    .reset       (reset),
    .rs1_ID      (rs1_ID),
    .rs2_ID      (rs2_ID),
    .use_rs1_ID  (use_rs1_ID),
    .use_rs2_ID  (use_rs2_ID),
    .rd_ID       (rd_ID),
    .regwrite_ID (regwrite_ID),
    .load_ID     (load_ID),
    .redirect_EX (redirect_EX),
    .stall_IF    (stall_IF),
    .bubble_ID   (bubble_ID),
    .flush_IF    (flush_IF),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall_cnt   (stall_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    total++;
    if (act !== 32'(exp)) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each producer remembers the cycle it entered EX; its distance from
  // now (0 EX, 1 MEM, 2 WB) decides stalls and bypass source.
  typedef struct {
    int         t;
    logic [4:0] rd;
    bit         ld;
  } prod_t;

  prod_t prods[$];
  int    cyc        = 0;
  bit    flush_next = 1'b0;
  int    m_fwd_a    = 0;
  int    m_fwd_b    = 0;
  int    m_cnt      = 0;

  function automatic int youngest(input logic u, input logic [4:0] rs, input int now,
                                  output bit is_ld);
    int best = -1;
    is_ld = 1'b0;
    if (u && rs != 5'd0) begin
      foreach (prods[i]) begin
        int d = now - prods[i].t;
        if (prods[i].rd == rs && d >= 0 && d <= 2 && (best < 0 || d < best)) begin
          best  = d;
          is_ld = prods[i].ld;
        end
      end
    end
    return best;
  endfunction

  function automatic int pick(input int d, input bit ld);
    if (!FWD)          return 0;
    if (d == 0 && !ld) return 1;
    if (d == 1)        return 2;
    return 0;
  endfunction

  always @(negedge clock) begin
    int da, db, e_st, e_bu, e_fl;
    bit la, lb, hz;
    da = youngest(use_rs1_ID, rs1_ID, cyc, la);
    db = youngest(use_rs2_ID, rs2_ID, cyc, lb);
    hz = FWD ? ((da == 0 && la) || (db == 0 && lb)) : (da >= 0 || db >= 0);
    e_st = 0; e_bu = 0; e_fl = 0;
    if (reset)            ;
    else if (redirect_EX) begin e_fl = 1; e_bu = 1; end
    else if (flush_next)  e_bu = 1;
    else if (hz)          begin e_st = 1; e_bu = 1; end
    chk("m_stall_IF",  stall_IF,  e_st);
    chk("m_bubble_ID", bubble_ID, e_bu);
    chk("m_flush_IF",  flush_IF,  e_fl);
    chk("m_fwd_a",     fwd_a,     reset ? 0 : m_fwd_a);
    chk("m_fwd_b",     fwd_b,     reset ? 0 : m_fwd_b);
    chk("m_stall_cnt", stall_cnt, reset ? 0 : m_cnt);
    if (reset) begin
      prods.delete();
      flush_next = 1'b0;
      m_fwd_a = 0; m_fwd_b = 0; m_cnt = 0;
    end else begin
      m_fwd_a = e_bu ? 0 : pick(da, la);
      m_fwd_b = e_bu ? 0 : pick(db, lb);
      if (e_bu == 0 && regwrite_ID && rd_ID != 5'd0)
        prods.push_back(prod_t'{cyc + 1, rd_ID, load_ID});
      flush_next = redirect_EX;
      if (e_st != 0 && m_cnt < (1 << CW) - 1) m_cnt++;
      while (prods.size() > 0 && cyc - prods[0].t > 2) void'(prods.pop_front());
    end
    cyc++;
  end

  task automatic drive(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic rw, input logic ld);
    rd_ID = rd; rs1_ID = rs1; rs2_ID = rs2;
    use_rs1_ID = u1; use_rs2_ID = u2; regwrite_ID = rw; load_ID = ld;
  endtask

  task automatic nop();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Hold the instruction in ID until it leaves; n = cycles it was stalled.
  task automatic issue(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic rw, input logic ld,
                       output int n);
    drive(rd, rs1, rs2, u1, u2, rw, ld);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (!stall_IF) begin
        tick();
        return;
      end
      n++;
      tick();
    end
    chk("issue_bound", n, 3);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_EX = 1'b0;
    nop();
    tick();
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [4:0] rd, rs1, rs2;
    logic       u1, u2, rw, ld;
  } instr_t;

  instr_t prog[10] = '{
    '{5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1},
    '{5'd4, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0},
    '{5'd0, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0},
    '{5'd7, 5'd4, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0},
    '{5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1},
    '{5'd9, 5'd7, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0},
    '{5'd0, 5'd9, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0},
    '{5'd9, 5'd9, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1},
    '{5'd2, 5'd1, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0},
    '{5'd5, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0}
  };

  initial begin
    int n;
    reset = 1'b1;
    redirect_EX = 1'b0;
    nop();
    @(negedge clock);
    chk("rst_stall",  stall_IF,  0);
    chk("rst_bubble", bubble_ID, 0);
    chk("rst_flush",  flush_IF,  0);
    chk("rst_fwd_a",  fwd_a,     0);
    chk("rst_cnt",    stall_cnt, 0);
    tick();
    reset = 1'b0;

    // addi x0,x0,1 then a reader of x0
    issue(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, n);
    issue(5'd9, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, n);
    chk("x0_stalls", n, 0);
    nop(); @(negedge clock);
    chk("x0_fwd_a", fwd_a, 0);
    chk("x0_fwd_b", fwd_b, 0);
    tick();

    // rs2 field names a producer but the instruction does not read rs2
    do_reset();
    issue(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, n);
    issue(5'd9, 5'd1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, n);
    chk("use_off_stalls", n, 0);

`ifdef FORWARDING_EN
    do_reset();
    issue(5'd5, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, n);
    issue(5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, n);
    chk("lw_use_stalls", n, 1);
    nop(); @(negedge clock);
    chk("lw_use_fwd_a", fwd_a, 2);
    chk("lw_use_fwd_b", fwd_b, 0);
    chk("lw_use_cnt", stall_cnt, 1);
    tick();

    do_reset();
    issue(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, n);
    issue(5'd7, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, n);
    chk("alu_use_stalls", n, 0);
    nop(); @(negedge clock);
    chk("alu_use_fwd_a", fwd_a, 1);
    chk("alu_use_fwd_b", fwd_b, 1);
    tick();

    issue(5'd5, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, n);
    issue(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, n);
    issue(5'd8, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, n);
    chk("mem_dist_stalls", n, 0);
    nop(); @(negedge clock);
    chk("mem_dist_fwd_a", fwd_a, 2);
    chk("mem_dist_fwd_b", fwd_b, 0);
    tick();
`else
    do_reset();
    issue(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, n);
    issue(5'd8, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, n);
    chk("raw_stalls", n, 3);
    nop(); @(negedge clock);
    chk("raw_cnt",   stall_cnt, 3);
    chk("raw_fwd_a", fwd_a, 0);
    chk("raw_fwd_b", fwd_b, 0);
    tick();

    issue(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, n);
    issue(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, n);
    issue(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, n);
    issue(5'd8, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, n);
    chk("wb_dist_stalls", n, 1);
    issue(5'd6, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, n);
    repeat (3) issue(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, n);
    issue(5'd8, 5'd6, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, n);
    chk("past_wb_stalls", n, 0);
`endif

    // redirect arriving while stalled
    do_reset();
    issue(5'd5, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, n);
    drive(5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clock); chk("pre_redir_stall", stall_IF, 1); tick();
    redirect_EX = 1'b1;
    @(negedge clock);
    chk("redir_flush",  flush_IF,  1);
    chk("redir_bubble", bubble_ID, 1);
    chk("redir_stall",  stall_IF,  0);
    tick();
    redirect_EX = 1'b0;
    @(negedge clock);
    chk("flush_bubble", bubble_ID, 1);
    chk("flush_stall",  stall_IF,  0);
    chk("flush_flush",  flush_IF,  0);
    tick();
    nop(); @(negedge clock);
    chk("run_bubble", bubble_ID, 0);
    chk("run_stall",  stall_IF,  0);
    tick();

    // reset arriving while stalled
    do_reset();
    issue(5'd5, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, n);
    drive(5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clock); chk("pre_rst_stall", stall_IF, 1); tick();
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_stall",  stall_IF,  0);
    chk("mid_rst_bubble", bubble_ID, 0);
    chk("mid_rst_cnt",    stall_cnt, 0);
    tick();
    reset = 1'b0;
    issue(5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, n);
    chk("post_rst_stalls", n, 0);
    nop(); @(negedge clock);
    chk("post_rst_cnt",   stall_cnt, 0);
    chk("post_rst_fwd_a", fwd_a, 0);
    tick();

    // counter saturation at all-ones
    do_reset();
    for (int k = 0; k < 8; k++) begin
      issue(5'd5, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, n);
      issue(5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, n);
    end
    nop(); @(negedge clock);
    chk("cnt_sat", stall_cnt, 7);
    tick();

    // mixed program, checked by the per-cycle model
    do_reset();
    foreach (prog[i]) issue(prog[i].rd, prog[i].rs1, prog[i].rs2,
                            prog[i].u1, prog[i].u2, prog[i].rw, prog[i].ld, n);
    nop();
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: CNT_W, default 16, width of the stall performance counter.
REQ-002 clock  in  1  single system clock; all state updates on posedge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 rs1_ID, rs2_ID  in  5 each  source register indices of the instruction in IF/ID.
REQ-005 use_rs1_ID, use_rs2_ID  in  1 each  instruction actually reads rs1/rs2.
REQ-006 rd_ID  in  5  destination index of the instruction in IF/ID.
REQ-007 regwrite_ID, load_ID  in  1 each  instruction writes rd; instruction is a load (lw/lh/lhu/lb/lbu).
REQ-008 redirect_EX  in  1  taken branch or jump resolved in EX this cycle.
REQ-009 stall_IF  out  1  hold PC and IF/ID this cycle.
REQ-010 bubble_ID  out  1  load zeroed controls into ID/EX this cycle.
REQ-011 flush_IF  out  1  load NOP into IF/ID this cycle.
REQ-012 fwd_a, fwd_b  out  2 each  EX operand source: 00 register file, 01 MEM result, 10 WB data.
REQ-013 stall_cnt  out  CNT_W  count of stall_IF cycles.

Function
REQ-014 The block SHALL keep a 3-entry scoreboard (EX, MEM, WB) of {valid, rd, load}, shifted every cycle.
REQ-015 The EX entry SHALL load {regwrite_ID && rd_ID!=0, rd_ID, load_ID}; it SHALL load invalid when bubble_ID is high.
REQ-016 A source SHALL match an entry only if its use bit is set, the entry is valid, and the rd values are equal; x0 never matches.
REQ-017 stall_IF and bubble_ID SHALL be combinational from scoreboard state and the ID inputs (zero-cycle latency).
REQ-018 The FSM SHALL have three states: RUN, STALL, FLUSH.
REQ-019 RUN->STALL when a hazard exists; STALL->RUN when the hazard clears; any state->FLUSH on redirect_EX; FLUSH->RUN after exactly one cycle.
REQ-020 In STALL, stall_IF=1, bubble_ID=1 and flush_IF=0.
REQ-021 In a redirect_EX cycle, flush_IF=1, bubble_ID=1 and stall_IF=0, overriding any hazard.
REQ-022 In FLUSH, bubble_ID=1, stall_IF=0 and flush_IF=0, and hazard detection SHALL be suppressed.
REQ-023 fwd_a/fwd_b SHALL be registered and valid during the consumer's EX cycle.
REQ-024 fwd selection: EX-entry match (non-load) SHALL give 01; otherwise a MEM-entry match SHALL give 10; otherwise 00. The youngest producer wins.
REQ-025 stall_cnt SHALL increment on every cycle with stall_IF=1 and saturate at all-ones.

Reset
REQ-026 While reset is high, the state SHALL be RUN and all scoreboard entries SHALL be invalid.
REQ-027 During reset, fwd_a=fwd_b=00, stall_cnt=0, and stall_IF=bubble_ID=flush_IF=0.
REQ-028 Reset asserted mid-stall or mid-flush SHALL abandon the operation without a residual stall.

Configuration
REQ-029 With FORWARDING_EN defined, a hazard SHALL be a match against a load in the EX entry only, giving a 1-cycle stall, and fwd_a/fwd_b SHALL be driven per REQ-024.
REQ-030 Without FORWARDING_EN, a hazard SHALL be any match against the EX, MEM or WB entry, the stall SHALL last up to 3 cycles, and fwd_a/fwd_b SHALL be tied to 00.

Structure
REQ-031 The shared package hazard_pkg SHALL hold the FSM state encoding, the fwd select constants (FWD_RF, FWD_MEM, FWD_WB) and the scoreboard entry typedef.
REQ-032 The scoreboard shift register and match logic SHALL be a sub-module, hazard_scoreboard.

Verification
REQ-033 FORWARDING_EN, lw x5 then add x6,x5,x1 -> stall_IF=bubble_ID=1 for exactly 1 cycle, then fwd_a=10 in add's EX cycle, stall_cnt=1.
REQ-034 FORWARDING_EN, add x5 then sub x7,x5,x5 -> no stall, fwd_a=fwd_b=01 in sub's EX cycle.
REQ-035 No FORWARDING_EN, add x5 then or x8,x5,x0 -> stall_IF=1 for 3 consecutive cycles, stall_cnt=3, fwd=00.
REQ-036 redirect_EX=1 while in STALL -> same cycle flush_IF=1, bubble_ID=1, stall_IF=0; next cycle FLUSH; then RUN.
REQ-037 Producer with rd=x0 (addi x0,x0,1), consumer reading x0 -> no stall, fwd=00.
REQ-038 reset=1 during STALL -> next cycle all outputs 0, scoreboard empty, and the following consumer proceeds unstalled.
